// File: rtl/audio_pkg.sv
// Shared state encoding and SRAM width constants for the audio session controller.
package audio_pkg;

  localparam int ADDR_W  = 20;
  localparam int DATA_W  = 16;
  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE       = 3'd0,
    ST_REC        = 3'd1,
    ST_REC_PAUSE  = 3'd2,
    ST_PLAY       = 3'd3,
    ST_PLAY_PAUSE = 3'd4
  } state_e;

endpackage

// File: rtl/session_timer.sv
// Elapsed-time counter: counts LRC falling edges while running, one second per
// SAMPLES_PER_SEC frames, saturating at 255 seconds.
module session_timer #(
  parameter int SAMPLES_PER_SEC = 32000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_run,
  input  logic       i_clr,
  input  logic       i_lrc,
  output logic [7:0] o_seconds
);

  localparam int CNT_W = (SAMPLES_PER_SEC > 1) ? $clog2(SAMPLES_PER_SEC) : 1;
  localparam logic [CNT_W-1:0] LAST_FRAME = CNT_W'(SAMPLES_PER_SEC - 1);

  logic [CNT_W-1:0] frame_q;
  logic             lrc_q;
  logic             lrc_fall;

  assign lrc_fall = lrc_q & ~i_lrc;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      frame_q   <= '0;
      o_seconds <= '0;
      lrc_q     <= 1'b0;
    end else begin
      lrc_q <= i_lrc;
      if (i_clr) begin
        frame_q   <= '0;
        o_seconds <= '0;
      end else if (i_run && lrc_fall) begin
        if (frame_q == LAST_FRAME) begin
          frame_q <= '0;
          if (o_seconds != 8'hFF) o_seconds <= o_seconds + 8'd1;
        end else begin
          frame_q <= frame_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/audio_session_ctrl.sv
// Record/playback session sequencer: key handling, SRAM arbitration between
// recorder and player, end-of-take tracking and elapsed-time reporting.
//
// state         | meaning
// ST_IDLE       | no session, SRAM released
// ST_REC        | recording, recorder owns SRAM
// ST_REC_PAUSE  | recording paused, timer frozen
// ST_PLAY       | playing back the last take, player owns SRAM
// ST_PLAY_PAUSE | playback paused, timer frozen
module audio_session_ctrl
  import audio_pkg::*;
#(
  parameter int                SAMPLES_PER_SEC = 32000,
  parameter logic [ADDR_W-1:0] MAX_ADDR        = 20'hFFFFF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_key_start,
  input  logic              i_key_pause,
  input  logic              i_key_stop,
  input  logic              i_mode,
  input  logic              i_lrc,
  input  logic              i_rec_wr,
  input  logic [ADDR_W-1:0] i_rec_addr,
  input  logic [DATA_W-1:0] i_rec_data,
  input  logic              i_play_rd,
  input  logic [ADDR_W-1:0] i_play_addr,
  output logic [DATA_W-1:0] o_play_data,
  output logic              o_rec_start,
  output logic              o_rec_pause,
  output logic              o_rec_stop,
  output logic              o_play_start,
  output logic              o_play_pause,
  output logic              o_play_stop,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic              o_sram_we_n,
  output logic              o_sram_oe_n,
  output logic [DATA_W-1:0] o_sram_dq,
  output logic              o_sram_dq_oe,
  input  logic [DATA_W-1:0] i_sram_dq,
  output logic [STATE_W-1:0] o_state,
  output logic [ADDR_W-1:0] o_end_addr,
  output logic [7:0]        o_seconds
);

  state_e state_q, state_d;
  logic   rec_start_d, rec_pause_d, rec_stop_d;
  logic   play_start_d, play_pause_d, play_stop_d;
  logic   tmr_clr, rec_begin;
  logic   end_valid_q;
  logic   wr_last_q, rd_last_q;
  logic   wr_done_last, rd_done_last;
  logic   wr_go, rd_go;
  logic   tmr_run;

  // Auto-stop fires on the edge that completes the final access.
  assign wr_done_last = ~o_sram_we_n & wr_last_q;
  assign rd_done_last = ~o_sram_oe_n & rd_last_q;

  always_comb begin
    state_d      = state_q;
    rec_start_d  = 1'b0;
    rec_pause_d  = 1'b0;
    rec_stop_d   = 1'b0;
    play_start_d = 1'b0;
    play_pause_d = 1'b0;
    play_stop_d  = 1'b0;
    tmr_clr      = 1'b0;
    rec_begin    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_key_start) begin
          if (!i_mode) begin
            state_d     = ST_REC;
            rec_start_d = 1'b1;
            tmr_clr     = 1'b1;
            rec_begin   = 1'b1;
          end else if (end_valid_q) begin
            state_d      = ST_PLAY;
            play_start_d = 1'b1;
            tmr_clr      = 1'b1;
          end
        end
      end
      ST_REC: begin
        if (wr_done_last || i_key_stop) begin
          state_d    = ST_IDLE;
          rec_stop_d = 1'b1;
        end else if (i_key_pause) begin
          state_d     = ST_REC_PAUSE;
          rec_pause_d = 1'b1;
        end
      end
      ST_REC_PAUSE: begin
        if (wr_done_last || i_key_stop) begin
          state_d    = ST_IDLE;
          rec_stop_d = 1'b1;
        end else if (i_key_start) begin
          state_d     = ST_REC;
          rec_start_d = 1'b1;
        end
      end
      ST_PLAY: begin
        if (rd_done_last || i_key_stop) begin
          state_d     = ST_IDLE;
          play_stop_d = 1'b1;
        end else if (i_key_pause) begin
          state_d      = ST_PLAY_PAUSE;
          play_pause_d = 1'b1;
        end
      end
      ST_PLAY_PAUSE: begin
        if (rd_done_last || i_key_stop) begin
          state_d     = ST_IDLE;
          play_stop_d = 1'b1;
        end else if (i_key_start) begin
          state_d      = ST_PLAY;
          play_start_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // An access is dropped when the session ends on the same edge, so the
  // SRAM is never driven while idle.
  assign wr_go   = i_rec_wr  && (state_q == ST_REC)  && (state_d != ST_IDLE);
  assign rd_go   = i_play_rd && (state_q == ST_PLAY) && (state_d != ST_IDLE);
  assign tmr_run = (state_q == ST_REC) || (state_q == ST_PLAY);
  assign o_state = state_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      o_rec_start  <= 1'b0;
      o_rec_pause  <= 1'b0;
      o_rec_stop   <= 1'b0;
      o_play_start <= 1'b0;
      o_play_pause <= 1'b0;
      o_play_stop  <= 1'b0;
    end else begin
      state_q      <= state_d;
      o_rec_start  <= rec_start_d;
      o_rec_pause  <= rec_pause_d;
      o_rec_stop   <= rec_stop_d;
      o_play_start <= play_start_d;
      o_play_pause <= play_pause_d;
      o_play_stop  <= play_stop_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_sram_we_n  <= 1'b1;
      o_sram_oe_n  <= 1'b1;
      o_sram_dq_oe <= 1'b0;
      o_sram_addr  <= '0;
      o_sram_dq    <= '0;
      o_play_data  <= '0;
      wr_last_q    <= 1'b0;
      rd_last_q    <= 1'b0;
    end else begin
      o_sram_we_n  <= ~wr_go;
      o_sram_dq_oe <= wr_go;
      o_sram_oe_n  <= ~rd_go;
      wr_last_q    <= wr_go && (i_rec_addr == MAX_ADDR);
      rd_last_q    <= rd_go && (i_play_addr == o_end_addr);
      if (wr_go) begin
        o_sram_addr <= i_rec_addr;
        o_sram_dq   <= i_rec_data;
      end else if (rd_go) begin
        o_sram_addr <= i_play_addr;
      end
      if (!o_sram_oe_n) o_play_data <= i_sram_dq;
    end
  end

  // A new take invalidates the previous one; the end address otherwise
  // survives idle so the last take can be replayed.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_end_addr  <= '0;
      end_valid_q <= 1'b0;
    end else if (rec_begin) begin
      o_end_addr  <= '0;
      end_valid_q <= 1'b0;
    end else if (wr_go) begin
      o_end_addr  <= i_rec_addr;
      end_valid_q <= 1'b1;
    end
  end

  session_timer #(
    .SAMPLES_PER_SEC(SAMPLES_PER_SEC)
  ) u_timer (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_run    (tmr_run),
    .i_clr    (tmr_clr),
    .i_lrc    (i_lrc),
    .o_seconds(o_seconds)
  );

endmodule

// File: doc/audio_session_ctrl.md
AUDIO_SESSION_CTRL -- requirements
Module: audio_session_ctrl

Interface
REQ-001 Parameters SHALL be: SAMPLES_PER_SEC (default 32000) = LRC frames per elapsed second; MAX_ADDR (default 20'hFFFFF) = last usable SRAM word.
REQ-002 i_clk  in  1  system clock; i_rst_n  in  1  reset: asynchronous, active-low.
REQ-003 i_key_start, i_key_pause, i_key_stop  in  1 each  single-cycle key pulses (debounced upstream).
REQ-004 i_mode  in  1  0 = record, 1 = play; sampled only in IDLE.
REQ-005 i_lrc  in  1  ADC/DAC frame clock, synchronous to i_clk.
REQ-006 i_rec_wr  in  1  recorder write strobe; i_rec_addr  in  20; i_rec_data  in  16.
REQ-007 i_play_rd  in  1  player read strobe; i_play_addr  in  20; o_play_data  out  16  read data.
REQ-008 o_rec_start, o_rec_pause, o_rec_stop, o_play_start, o_play_pause, o_play_stop  out  1 each  single-cycle command pulses.
REQ-009 o_sram_addr  out  20; o_sram_we_n, o_sram_oe_n  out  1; o_sram_dq  out  16; o_sram_dq_oe  out  1; i_sram_dq  in  16.
REQ-010 o_state  out  3  current state code; o_end_addr  out  20  last recorded address; o_seconds  out  8  elapsed seconds.

Function
REQ-011 States SHALL be IDLE(0), REC(1), REC_PAUSE(2), PLAY(3), PLAY_PAUSE(4), both via the shared state enum.
REQ-012 IDLE + i_key_start: i_mode=0 -> REC, pulse o_rec_start, clear o_seconds and o_end_addr; i_mode=1 and o_end_addr valid -> PLAY, pulse o_play_start, clear o_seconds; i_mode=1 with nothing recorded -> remain IDLE.
REQ-013 REC/PLAY + i_key_pause -> matching PAUSE state, pulse matching *_pause; PAUSE + i_key_start -> resume, pulse matching *_start.
REQ-014 Any non-IDLE state + i_key_stop -> IDLE, pulse matching *_stop.
REQ-015 Priority when keys coincide: stop > pause > start.
REQ-016 All command pulses SHALL be registered, asserted exactly one cycle, the cycle after the triggering condition.
REQ-017 REC: each i_rec_wr updates o_end_addr to i_rec_addr and sets a recorded-valid flag.
REQ-018 REC: write with i_rec_addr == MAX_ADDR -> auto-stop (IDLE, pulse o_rec_stop) after that write completes.
REQ-019 PLAY: read with i_play_addr == o_end_addr -> auto-stop (IDLE, pulse o_play_stop) after data returns.
REQ-020 SRAM ownership: REC/REC_PAUSE -> recorder; PLAY/PLAY_PAUSE -> player; IDLE -> none (we_n=1, oe_n=1, dq_oe=0).
REQ-021 Write: i_rec_wr in REC -> next cycle o_sram_addr=i_rec_addr, o_sram_dq=i_rec_data, dq_oe=1, we_n=0 for exactly one cycle; strobes outside REC ignored.
REQ-022 Read: i_play_rd in PLAY -> next cycle o_sram_addr=i_play_addr, oe_n=0; o_play_data captures i_sram_dq one cycle later (2-cycle latency); o_play_data holds otherwise.
REQ-023 Elapsed timer: count i_lrc falling edges in REC/PLAY only; at SAMPLES_PER_SEC-1 wrap frame counter, increment o_seconds, saturating at 255; frozen in PAUSE states.
REQ-024 o_end_addr retained through IDLE so repeated playback plays the last take.

Reset
REQ-025 On i_rst_n low: state IDLE, all command pulses 0, we_n=1, oe_n=1, dq_oe=0, o_sram_addr=0, o_sram_dq=0, o_play_data=0, o_end_addr=0, recorded-valid=0, o_seconds=0, frame counter 0, previous-lrc 0.
REQ-026 Reset mid-write SHALL deassert we_n asynchronously; no command pulse issued on exit from reset.

Structure
REQ-027 State enum, state codes and SRAM width constants (address 20, data 16) SHALL live in shared package audio_pkg.
REQ-028 Elapsed timer SHALL be sub-module session_timer (i_clk, i_rst_n, i_run, i_clr, i_lrc, o_seconds).

Verification
REQ-029 IDLE, mode=0, start pulse -> o_rec_start one cycle later, o_state=1; four i_rec_wr at addr 0..3 -> four one-cycle we_n lows, o_end_addr=3.
REQ-030 REC, pause and stop keys same cycle -> o_rec_stop only, o_state=0.
REQ-031 After 3-word record, mode=1 start, reads addr 0..2 with SRAM returning 16'hA5A5 -> o_play_data=16'hA5A5 two cycles after each strobe; read of addr 2 -> o_play_stop, o_state=0.
REQ-032 mode=1 start after reset -> no pulse, stays IDLE.
REQ-033 SAMPLES_PER_SEC=4, REC, 8 LRC falling edges -> o_seconds=2; pause, 4 more edges -> o_seconds remains 2.
REQ-034 MAX_ADDR=5, write at addr 5 -> we_n pulse then o_rec_stop; reset asserted during a write -> we_n=1 immediately.
